// File: rtl/segment_capture_decoder.sv
// rtl/segment_capture_decoder.sv - debounced seven-segment capture and nibble decoder
// Optional macro SEG_HEX_EN: also recognise the A-F glyphs.
module segment_capture_decoder #(
  parameter int STABLE_CYCLES = 250000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Segment_A,
  input  logic       i_Segment_B,
  input  logic       i_Segment_C,
  input  logic       i_Segment_D,
  input  logic       i_Segment_E,
  input  logic       i_Segment_F,
  input  logic       i_Segment_G,
  output logic [3:0] o_Nibble,
  output logic       o_Valid,
  output logic       o_DV,
  output logic       o_Error,
  output logic [7:0] o_Error_Count
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] COUNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [6:0]    raw;
  logic [6:0]    sync1;
  logic [6:0]    sync2;
  logic [6:0]    candidate;
  logic [6:0]    committed;
  logic [CW-1:0] count;
  logic          commit;
  logic          dec_hit;
  logic [3:0]    dec_val;

  // Lines are active-low; everything downstream works on lit = 1, bit order {G..A}.
  assign raw = ~{i_Segment_G, i_Segment_F, i_Segment_E, i_Segment_D,
                 i_Segment_C, i_Segment_B, i_Segment_A};

  assign commit = (sync2 == candidate) && (count == COUNT_MAX) && (candidate != committed);

  always_comb begin
    dec_hit = 1'b1;
    dec_val = 4'h0;
    case (candidate)
      7'h3F: dec_val = 4'h0;
      7'h06: dec_val = 4'h1;
      7'h5B: dec_val = 4'h2;
      7'h4F: dec_val = 4'h3;
      7'h66: dec_val = 4'h4;
      7'h6D: dec_val = 4'h5;
      7'h7D: dec_val = 4'h6;
      7'h07: dec_val = 4'h7;
      7'h7F: dec_val = 4'h8;
      7'h6F: dec_val = 4'h9;
`ifdef SEG_HEX_EN
      7'h77: dec_val = 4'hA;
      7'h7C: dec_val = 4'hB;
      7'h39: dec_val = 4'hC;
      7'h5E: dec_val = 4'hD;
      7'h79: dec_val = 4'hE;
      7'h71: dec_val = 4'hF;
`endif
      default: dec_hit = 1'b0;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      sync1         <= '0;
      sync2         <= '0;
      candidate     <= '0;
      committed     <= '0;
      count         <= '0;
      o_Nibble      <= 4'h0;
      o_Valid       <= 1'b0;
      o_DV          <= 1'b0;
      o_Error       <= 1'b0;
      o_Error_Count <= 8'h00;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      o_DV    <= 1'b0;
      o_Error <= 1'b0;

      if (sync2 != candidate) begin
        candidate <= sync2;
        count     <= '0;
      end else if (count < COUNT_MAX) begin
        count <= count + CW'(1);
      end

      // The candidate != committed term is what stops a held pattern re-committing.
      if (commit) begin
        committed <= candidate;
        if (dec_hit) begin
          o_Nibble <= dec_val;
          o_Valid  <= 1'b1;
          o_DV     <= 1'b1;
        end else if (candidate == 7'h00) begin
          o_Valid <= 1'b0;
        end else begin
          o_Valid <= 1'b0;
          o_Error <= 1'b1;
          if (o_Error_Count != 8'hFF) begin
            o_Error_Count <= o_Error_Count + 8'h01;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_segment_capture_decoder.sv
// tb/tb_segment_capture_decoder.sv - scoreboard bench for segment_capture_decoder
module tb_segment_capture_decoder;

  localparam int STABLE = 4;

  typedef struct packed {
    logic       is_err;
    logic [3:0] nib;
    logic       valid;
    logic [7:0] cnt;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_l;
  logic [6:0] seg_n;
  logic [3:0] nibble;
  logic       valid;
  logic       dv;
  logic       err;
  logic [7:0] err_count;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int dv_total = 0;
  int err_total = 0;
  int last_dv_cyc = -1;
  ev_t exp_q[$];

  string glyphs[16] = '{"ABCDEF", "BC", "ABDEG", "ABCDG", "BCFG", "ACDFG", "ACDEFG", "ABC",
                        "ABCDEFG", "ABCDFG", "ABCEFG", "CDEFG", "ADEF", "BCDEG", "ADEFG", "AEFG"};

  segment_capture_decoder #(.STABLE_CYCLES(STABLE)) dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_l),
    .i_Segment_A  (seg_n[0]),
    .i_Segment_B  (seg_n[1]),
    .i_Segment_C  (seg_n[2]),
    .i_Segment_D  (seg_n[3]),
    .i_Segment_E  (seg_n[4]),
    .i_Segment_F  (seg_n[5]),
    .i_Segment_G  (seg_n[6]),
    .o_Nibble     (nibble),
    .o_Valid      (valid),
    .o_DV         (dv),
    .o_Error      (err),
    .o_Error_Count(err_count)
  );

  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [6:0] seg_of(input string s);
    logic [6:0] r = '0;
    for (int i = 0; i < s.len(); i++) r[s[i] - 8'h41] = 1'b1;
    return r;
  endfunction

  function automatic bit ref_decode(input logic [6:0] p, output logic [3:0] v);
    int lim;
`ifdef SEG_HEX_EN
    lim = 16;
`else
    lim = 10;
`endif
    v = 4'h0;
    for (int i = 0; i < lim; i++) begin
      if (seg_of(glyphs[i]) == p) begin
        v = 4'(i);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // Reference: a pattern commits once the synchronised stream has shown it STABLE+1 times in a row.
  logic [6:0] m_p1, m_p2, m_last, m_committed;
  logic [3:0] m_nib;
  logic       m_valid;
  logic [7:0] m_cnt;
  int         m_run;

  always @(posedge clk) begin
    logic [3:0] v;
    if (!rst_l) begin
      m_p1 = '0; m_p2 = '0; m_last = '0; m_committed = '0;
      m_run = 1; m_nib = '0; m_valid = 1'b0; m_cnt = '0;
      exp_q.delete();
    end else begin
      if (m_p2 == m_last) begin
        if (m_run < 1000) m_run++;
      end else begin
        m_run  = 1;
        m_last = m_p2;
      end
      if (m_run >= STABLE + 1 && m_p2 != m_committed) begin
        m_committed = m_p2;
        if (ref_decode(m_p2, v)) begin
          m_nib = v;
          m_valid = 1'b1;
          exp_q.push_back('{1'b0, m_nib, m_valid, m_cnt});
        end else if (m_p2 == 7'h00) begin
          m_valid = 1'b0;
        end else begin
          m_valid = 1'b0;
          if (m_cnt != 8'hFF) m_cnt++;
          exp_q.push_back('{1'b1, m_nib, m_valid, m_cnt});
        end
      end
      m_p2 = m_p1;
      m_p1 = ~seg_n;
    end
  end

  always @(negedge clk) begin
    ev_t e;
    if (dv && err) check("dv_err_overlap", 1, 0);
    if (dv) begin
      dv_total++;
      last_dv_cyc = cyc;
    end
    if (err) err_total++;
    if (dv || err) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {dv, err}, 0);
      end else begin
        e = exp_q.pop_front();
        check("commit_event", {err, nibble, valid, err_count}, e);
      end
    end else if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("missing_pulse", 0, 1);
    end
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int base, eb, start, rel;
    logic [6:0] p7, pat;
    seg_n = 7'h7F;
    rst_l = 1'b0;
    hold(3);
    check("rst_nibble", nibble, 0);
    check("rst_valid", valid, 0);
    check("rst_dv", dv, 0);
    check("rst_error", err, 0);
    check("rst_count", err_count, 0);
    rst_l = 1'b1;
    hold(3);

    base = dv_total;
    start = cyc;
    seg_n = ~seg_of("ABCDG");
    hold(12);
    check("t1_dv_cycle", last_dv_cyc, start + 7);
    check("t1_dv_count", dv_total, base + 1);
    check("t1_nibble", nibble, 3);
    check("t1_valid", valid, 1);
    check("t1_count", err_count, 0);

    base = dv_total;
    p7 = seg_of("ABC");
    seg_n = ~p7;
    hold(3);
    seg_n = ~(p7 & 7'b1111101);
    hold(1);
    start = cyc;
    seg_n = ~p7;
    hold(10);
    check("t2_dv_cycle", last_dv_cyc, start + 7);
    check("t2_nibble", nibble, 7);
    hold(20);
    check("t2_dv_once", dv_total, base + 1);

    eb = err_total;
    base = dv_total;
    seg_n = ~seg_of("A");
    hold(10);
    check("t3_err_once", err_total, eb + 1);
    check("t3_valid", valid, 0);
    check("t3_nibble_held", nibble, 7);
    check("t3_count", err_count, 1);
    seg_n = 7'h7F;
    hold(10);
    check("t3_blank_err", err_total, eb + 1);
    check("t3_blank_dv", dv_total, base);
    check("t3_blank_valid", valid, 0);

    seg_n = ~seg_of("ADEFG");
    hold(10);
`ifdef SEG_HEX_EN
    check("t4_nibble", nibble, 4'hE);
    check("t4_valid", valid, 1);
    check("t4_dv", dv_total, base + 1);
`else
    check("t4_err", err_total, eb + 2);
    check("t4_valid", valid, 0);
    check("t4_count", err_count, 2);
`endif

    repeat (300) begin
      seg_n = ~seg_of("A");
      hold(10);
      seg_n = 7'h7F;
      hold(10);
    end
    check("t5_saturate", err_count, 8'hFF);

    base = dv_total;
    seg_n = ~seg_of("ACDFG");
    hold(4);
    rst_l = 1'b0;
    hold(1);
    rst_l = 1'b1;
    rel = cyc;
    hold(12);
    check("t6_dv_count", dv_total, base + 1);
    check("t6_dv_cycle", last_dv_cyc, rel + 7);
    check("t6_nibble", nibble, 5);
    check("t6_count", err_count, 0);

    repeat (200) begin
      if ($urandom_range(0, 9) < 6) pat = seg_of(glyphs[$urandom_range(0, 15)]);
      else pat = 7'($urandom_range(0, 127));
      seg_n = ~pat;
      hold($urandom_range(1, 9));
      if ($urandom_range(0, 29) == 0) begin
        rst_l = 1'b0;
        hold(1);
        rst_l = 1'b1;
      end
    end
    seg_n = 7'h7F;
    hold(12);
    check("sb_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
